// File: rtl/sid_regs_pkg.sv
// Shared constants, field positions and FSM state
// for the SPI-fed SID voice register bank.
package sid_regs_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  localparam logic [2:0] REG_FREQ_LO = 3'd0;
  localparam logic [2:0] REG_FREQ_HI = 3'd1;
  localparam logic [2:0] REG_PW_LO   = 3'd2;
  localparam logic [2:0] REG_PW_HI   = 3'd3;
  localparam logic [2:0] REG_ATTACK  = 3'd4;
  localparam logic [2:0] REG_SUSTAIN = 3'd5;
  localparam logic [2:0] REG_WAVE    = 3'd6;
  localparam logic [2:0] REG_CTRL    = 3'd7;

  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 13;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT,
    DONE
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer with registered-history
// rise/fall pulse outputs.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_shadow_regs.sv
// SPI write-only slave feeding SID voice registers,
// with lo/hi shadow staging on 16-bit words.
module spi_shadow_regs #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [15:0] sid_frequency,
  output logic [15:0] sid_duration,
  output logic [7:0]  sid_attack,
  output logic [7:0]  sid_sustain,
  output logic [7:0]  sid_waveform,
  output logic        wr_strobe,
  output logic [2:0]  wr_addr,
  output logic        frame_err
);

  import sid_regs_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic mosi_q;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk (clk),
    .rst (rst),
    .d   (spi_clk),
    .q   (sclk_q),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk (clk),
    .rst (rst),
    .d   (spi_cs_n),
    .q   (cs_q),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_sr <= '0;
    else     mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
  end

  assign mosi_q = mosi_sr[SYNC_STAGES-1];

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [15:0]      shreg, shreg_nx;
  logic             err_nx;
  logic             last_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      shreg <= shreg_nx;
    end
  end

  // A cs_n rise coinciding with the final bit still completes the frame.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    err_nx   = 1'b0;
    last_bit = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
        end
      end
      SHIFT: begin
        if (cnt == CNT_FULL) begin
          state_nx = COMMIT;
        end else begin
          last_bit = sclk_rise && (cnt == CNT_LAST);
          if (sclk_rise) begin
            shreg_nx = {shreg[14:0], mosi_q};
            cnt_nx   = cnt + 1'b1;
          end
          if (cs_rise && !last_bit) begin
            state_nx = IDLE;
            err_nx   = 1'b1;
          end
        end
      end
      COMMIT: state_nx = DONE;
      DONE: begin
        if (cs_q) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [2:0] addr;
  logic [7:0] data;
  logic [7:0] freq_lo, pw_lo;

  assign addr = shreg[ADDR_MSB:ADDR_LSB];
  assign data = shreg[DATA_MSB:DATA_LSB];

  always_ff @(posedge clk) begin
    if (rst) begin
      sid_frequency <= '0;
      sid_duration  <= '0;
      sid_attack    <= '0;
      sid_sustain   <= '0;
      sid_waveform  <= '0;
      freq_lo       <= '0;
      pw_lo         <= '0;
      wr_strobe     <= 1'b0;
      wr_addr       <= '0;
      frame_err     <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= err_nx;
      if (state == COMMIT) begin
        wr_strobe <= 1'b1;
        wr_addr   <= addr;
        unique case (addr)
          REG_FREQ_LO: freq_lo       <= data;
          REG_FREQ_HI: sid_frequency <= {data, freq_lo};
          REG_PW_LO:   pw_lo         <= data;
          REG_PW_HI:   sid_duration  <= {data, pw_lo};
          REG_ATTACK:  sid_attack    <= data;
          REG_SUSTAIN: sid_sustain   <= data;
          REG_WAVE:    sid_waveform  <= data;
          REG_CTRL: begin
            if (data[0]) begin
              sid_frequency <= '0;
              sid_duration  <= '0;
              sid_attack    <= '0;
              sid_sustain   <= '0;
              sid_waveform  <= '0;
              freq_lo       <= '0;
              pw_lo         <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{sclk_q, sclk_fall, shreg[12:8]};

endmodule

// File: tb/tb_spi_shadow_regs.sv
// Directed bench for spi_shadow_regs: SPI frames
// bit-banged on clk negedges, outputs checked on negedges.
module tb_spi_shadow_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_clk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [15:0] sid_frequency;
  logic [15:0] sid_duration;
  logic [7:0]  sid_attack;
  logic [7:0]  sid_sustain;
  logic [7:0]  sid_waveform;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  int n_err = 0;
  logic [2:0] last_addr = '0;

  spi_shadow_regs #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_clk      (spi_clk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .sid_frequency(sid_frequency),
    .sid_duration (sid_duration),
    .sid_attack   (sid_attack),
    .sid_sustain  (sid_sustain),
    .sid_waveform (sid_waveform),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_strobe) begin
        n_strobe++;
        last_addr = wr_addr;
      end
      if (frame_err) n_err++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = w[15-i];
      tick(4);
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
    end
    spi_mosi = 1'b0;
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_hi();
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic frame(input logic [15:0] w);
    cs_lo();
    send_bits(w, 16);
    cs_hi();
  endtask

  initial begin
    rst      = 1'b1;
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tick(4);
    chk("rst_freq", 32'(sid_frequency), 32'h0);
    chk("rst_dur", 32'(sid_duration), 32'h0);
    chk("rst_wave", 32'(sid_waveform), 32'h0);
    chk("rst_strobe", 32'(wr_strobe), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("miso", 32'(spi_miso), 32'h0);
    rst = 1'b0;
    tick(6);

    frame(16'h0034);
    chk("lo_only_freq", 32'(sid_frequency), 32'h0);
    chk("lo_strobe_cnt", 32'(n_strobe), 32'd1);
    chk("lo_addr", 32'(last_addr), 32'd0);
    frame(16'h2012);
    chk("hi_freq", 32'(sid_frequency), 32'h1234);
    chk("hi_strobe_cnt", 32'(n_strobe), 32'd2);
    chk("hi_addr", 32'(last_addr), 32'd1);

    cs_lo();
    send_bits(16'hC021, 15);
    spi_mosi = 1'b1;
    tick(4);
    spi_clk = 1'b1;
    tick(4);
    chk("lat_wave_early", 32'(sid_waveform), 32'h0);
    chk("lat_strobe_early", 32'(wr_strobe), 32'h0);
    tick(1);
    chk("lat_wave", 32'(sid_waveform), 32'h21);
    chk("lat_strobe", 32'(wr_strobe), 32'h1);
    chk("lat_addr", 32'(wr_addr), 32'd6);
    tick(1);
    chk("lat_strobe_off", 32'(wr_strobe), 32'h0);
    tick(2);
    spi_clk = 1'b0;
    spi_mosi = 1'b0;
    cs_hi();
    chk("lat_strobe_cnt", 32'(n_strobe), 32'd3);

    cs_lo();
    send_bits(16'h8099, 10);
    cs_hi();
    chk("abort_ferr_cycles", 32'(n_err), 32'd1);
    chk("abort_attack", 32'(sid_attack), 32'h0);
    chk("abort_no_strobe", 32'(n_strobe), 32'd3);

    cs_lo();
    send_bits(16'hA0AA, 16);
    send_bits(16'hF000, 4);
    cs_hi();
    chk("extra_sustain", 32'(sid_sustain), 32'hAA);
    chk("extra_strobe_cnt", 32'(n_strobe), 32'd4);

    frame(16'h4078);
    chk("pw_lo_hold", 32'(sid_duration), 32'h0);
    frame(16'h6056);
    chk("pw_word", 32'(sid_duration), 32'h5678);
    frame(16'h8011);
    chk("attack", 32'(sid_attack), 32'h11);

    frame(16'hE001);
    chk("clr_freq", 32'(sid_frequency), 32'h0);
    chk("clr_dur", 32'(sid_duration), 32'h0);
    chk("clr_attack", 32'(sid_attack), 32'h0);
    chk("clr_sustain", 32'(sid_sustain), 32'h0);
    chk("clr_wave", 32'(sid_waveform), 32'h0);
    chk("clr_addr", 32'(last_addr), 32'd7);
    chk("clr_strobe_cnt", 32'(n_strobe), 32'd8);
    frame(16'h2056);
    chk("clr_freq_shadow", 32'(sid_frequency), 32'h5600);
    frame(16'h609A);
    chk("clr_pw_shadow", 32'(sid_duration), 32'h9A00);

    frame(16'hE000);
    chk("ctrl_noop_freq", 32'(sid_frequency), 32'h5600);
    chk("ctrl_noop_strobe", 32'(n_strobe), 32'd11);

    cs_lo();
    send_bits(16'hC0FF, 8);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("midrst_freq", 32'(sid_frequency), 32'h0);
    spi_cs_n = 1'b1;
    tick(8);
    chk("midrst_wave", 32'(sid_waveform), 32'h0);
    frame(16'hC055);
    chk("midrst_wave_new", 32'(sid_waveform), 32'h55);
    chk("midrst_no_ferr", 32'(n_err), 32'd1);
    chk("midrst_strobe_cnt", 32'(n_strobe), 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_shadow_regs.md
Name: spi_shadow_regs

Overview:
- SPI-slave front end and register bank that feeds the SID voice its control words (frequency, pulse width, attack, sustain, waveform).
- Oversamples the SPI pins in the system clock domain and assembles 16-bit write frames.
- 16-bit registers use lo/hi shadow staging, so the voice never sees a half-updated word.
- Write-only; MISO is tied low.

Parameters:
- SYNC_STAGES, 2: flop stages per SPI input synchronizer (minimum 2).
- FRAME_BITS, 16: bits per frame. Fixed by protocol; any other value is unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- spi_clk  in  1  SPI SCLK, asynchronous, CPOL=0 CPHA=0
- spi_cs_n  in  1  SPI chip select, active low, asynchronous
- spi_mosi  in  1  SPI data in, MSB first
- spi_miso  out  1  constant 0
- sid_frequency  out  16  committed frequency word
- sid_duration  out  16  committed pulse-width word
- sid_attack  out  8  attack/decay byte
- sid_sustain  out  8  sustain/release byte
- sid_waveform  out  8  waveform/control byte
- wr_strobe  out  1  one-clk pulse for each accepted frame
- wr_addr  out  3  address of the last accepted frame; valid while wr_strobe=1
- frame_err  out  1  one-clk pulse when a frame is aborted short

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset: all outputs, shadow registers, bit counter and state go to 0; the FSM goes to IDLE. spi_miso is always 0.
- Synchronizers: spi_clk, spi_cs_n and spi_mosi each pass through SYNC_STAGES flops with identical depth, so they stay aligned.
- Edge detection: one extra register on synced sclk gives sclk_rise = sync & ~prev. Synced cs_n is edge-detected the same way.
- Input timing: SCLK high and low phases must each be ≥ 3 clk periods. MOSI must be stable ≥ 3 clk before each SCLK rise.
- Frame format: [15:13] addr, [12:8] reserved (ignored), [7:0] data. Shift left on each sclk_rise while in SHIFT.
- FSM states:
  - IDLE: cs_n synced high. Falling cs_n → SHIFT, with bit counter cleared.
  - SHIFT: each sclk_rise shifts in one bit and increments the counter. On the 16th rise, go to COMMIT for one cycle. cs_n rising before the count reaches 16 → frame_err pulse next cycle, frame discarded, go to IDLE.
  - COMMIT: perform the register write, assert wr_strobe and wr_addr, then go to DONE.
  - DONE: further sclk_rise are ignored (extra bits dropped). cs_n rising → IDLE.
- Latency: outputs change exactly SYNC_STAGES+2 clk edges after the first clk edge that samples the 16th SCLK high (±1 clk of sampling uncertainty at the pin).
- Register map (applied in COMMIT):
  - 0: freq_lo shadow ← data. sid_frequency unchanged.
  - 1: sid_frequency ← {data, freq_lo shadow}.
  - 2: pw_lo shadow ← data. sid_duration unchanged.
  - 3: sid_duration ← {data, pw_lo shadow}.
  - 4: sid_attack ← data.
  - 5: sid_sustain ← data.
  - 6: sid_waveform ← data.
  - 7: if data[0]=1, soft clear: every output register and shadow goes to 0 in the same cycle (wr_strobe still pulses). If data[0]=0, no effect except wr_strobe.
- Shadow rules: a shadow persists across frames until it is overwritten. Writing hi without a prior lo reuses the old shadow value. A lo write never alters the committed word.
- Reset priority: rst mid-frame aborts with no write and no frame_err.
- cs_n re-assertion: cs_n high for < SYNC_STAGES+1 clk may be missed; a minimum of 4 clk deassertion between frames is required.
- Simultaneous 16th sclk_rise and cs_n rise: treated as a complete frame, with COMMIT taken before returning to IDLE.

Decomposition:
- Package sid_regs_pkg holds:
  - FRAME_BITS.
  - Address constants REG_FREQ_LO..REG_CTRL (0..7).
  - Field positions ADDR_MSB/LSB and DATA_MSB/LSB.
  - FSM state enum {IDLE, SHIFT, COMMIT, DONE}.
- Sub-module sync_edge: an N-stage synchronizer plus rise/fall pulse outputs, instantiated for spi_clk and spi_cs_n. MOSI uses a plain synchronizer of the same depth.

Test Plan:
- Frame 0x0034 then 0x2012 → after the second frame, sid_frequency=0x1234; after the first frame alone, sid_frequency is still 0x0000. wr_strobe pulses twice, with wr_addr 0 then 1.
- Frame 0xC021 (addr 6, data 0x21) → sid_waveform=0x21 exactly SYNC_STAGES+2 clk after the 16th SCLK is sampled high, with a one-clk wr_strobe.
- Frame 0x8099 with 10 SCLKs then CS high → frame_err one-clk pulse. sid_attack stays 0x00 and no wr_strobe.
- Frame 0xA0AA followed by 4 extra SCLKs before CS high → sid_sustain=0xAA, exactly one wr_strobe, extra bits ignored.
- All registers nonzero, then frame 0xE001 → every output and shadow goes to 0. Next 0x2056 gives sid_frequency=0x5600.
- rst asserted after 8 bits of 0xC0FF, then a full 0xC055 → sid_waveform=0x55 with no frame_err, and the first frame is never written.
